// File: rtl/gray_pkg.sv
// Shared constants and types for the Gray-code counter.
// Direction encodings and the per-cycle command type used by gray_counter.
package gray_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MIN_WIDTH = 2;
   localparam int unsigned MAX_WIDTH = 32;

   // Resolved per-cycle command, highest priority first: clear, load, step, hold.
   typedef enum logic [1:0] {
      CmdHold,
      CmdStep,
      CmdLoad,
      CmdClr
   } cmd_e;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] gray_i,
   output logic [DATA_WIDTH-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      bin_o[DATA_WIDTH-1] = gray_i[DATA_WIDTH-1];
      for (int i = int'(DATA_WIDTH) - 2; i >= 0; i--) begin
         bin_o[i] = bin_o[i+1] ^ gray_i[i];
      end
   end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered binary and Gray outputs, clear, Gray load and wrap pulse.
// The binary register is the source of truth; the Gray register is kept in lockstep with it.
module gray_counter
   import gray_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] load_gray_i,
   input  logic                  en_i,
   input  logic                  dir_i,
   output logic [DATA_WIDTH-1:0] data_gray_o,
   output logic [DATA_WIDTH-1:0] data_bin_o,
   output logic                  wrap_o,
   output logic                  tc_o
);

   localparam logic [DATA_WIDTH-1:0] One = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic [DATA_WIDTH-1:0] gray_q, gray_d;
   logic [DATA_WIDTH-1:0] load_bin;
   logic                  wrap_q, wrap_d;
   logic                  at_max, at_min;
   cmd_e                  cmd;

   gray2bin #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_conv (
      .gray_i (load_gray_i),
      .bin_o  (load_bin)
   );

   always_comb begin
      cmd = CmdHold;
      if (clr_i) begin
         cmd = CmdClr;
      end else if (load_i) begin
         cmd = CmdLoad;
      end else if (en_i) begin
         cmd = CmdStep;
      end
   end

   assign at_max = &bin_q;
   assign at_min = ~|bin_q;
   // Terminal count follows the live direction so a same-cycle dir change is honoured.
   assign tc_o   = (dir_i == DIR_UP) ? at_max : at_min;

   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      wrap_d = 1'b0;
      unique case (cmd)
         CmdClr: begin
            bin_d  = '0;
            gray_d = '0;
         end
         CmdLoad: begin
            bin_d  = load_bin;
            gray_d = load_gray_i;
         end
         CmdStep: begin
            bin_d  = (dir_i == DIR_UP) ? bin_q + One : bin_q - One;
            gray_d = bin_d ^ (bin_d >> 1);
            wrap_d = tc_o;
         end
         CmdHold: begin
            bin_d  = bin_q;
         end
         default: begin
            bin_d  = bin_q;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign data_bin_o  = bin_q;
   assign data_gray_o = gray_q;
   assign wrap_o      = wrap_q;

endmodule
